// File: rtl/vpc_ctrl_if.sv
// Fetch-stage bus between the IF pipeline logic and the virtual PC controller.
// The pipeline side is the master; vpc_ctrl is the slave.
interface vpc_ctrl_if #(
   parameter int WIDTH = 32
);
   // e is a plain advance strobe with no ready return: every request the
   // pipeline presents while e=1 is consumed on that clock edge.
   // exc_req and adel are the exceptions to this: they are taken even when e=0.
   logic             e;
   logic             br_taken;
   logic [WIDTH-1:0] br_target;
   logic             jmp;
   logic [WIDTH-1:0] jmp_target;
   logic             exc_req;
   logic [4:0]       exc_code;
   logic             in_delay_slot;
   logic             eret;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] epc;
   logic [4:0]       cause;
   logic             bd;
   logic             exl;
   logic [WIDTH-1:0] badvaddr;
   logic             redirect;

   modport master (
      output e, br_taken, br_target, jmp, jmp_target,
             exc_req, exc_code, in_delay_slot, eret,
      input  q, epc, cause, bd, exl, badvaddr, redirect
   );

   modport slave (
      input  e, br_taken, br_target, jmp, jmp_target,
             exc_req, exc_code, in_delay_slot, eret,
      output q, epc, cause, bd, exl, badvaddr, redirect
   );
endinterface

// File: rtl/vpc_ctrl.sv
// MIPS32 fetch PC with fixed-priority next-PC selection and exception state.
// The mode FSM is observable directly on bus.exl (1 = KERNEL_EXC, 0 = NORMAL).
module vpc_ctrl #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h8000_0000,
   parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180,
   parameter int               INC          = 4,
   parameter int               ALIGN_BITS   = 2
) (
   input  logic              clk,
   input  logic              clrn,
   vpc_ctrl_if.slave         bus
);
   typedef enum logic {NORMAL = 1'b0, KERNEL_EXC = 1'b1} mode_t;

   // ALIGN_BITS=0 gives an all-zero mask, which disables the address check.
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
   localparam logic [4:0]       CAUSE_ADEL = 5'd4;

   mode_t            state, state_n;
   logic [WIDTH-1:0] q_r, q_n;
   logic [WIDTH-1:0] epc_r, epc_n;
   logic [4:0]       cause_r, cause_n;
   logic             bd_r, bd_n;
   logic [WIDTH-1:0] badvaddr_r, badvaddr_n;
   logic             redirect_r, redirect_n;

   logic [WIDTH-1:0] sel_target;
   logic             adel;

   // jmp outranks br_taken, so only the jump target is checked when both fire.
   assign sel_target = bus.jmp ? bus.jmp_target : bus.br_target;
   assign adel       = (bus.jmp || bus.br_taken) && ((sel_target & ALIGN_MASK) != '0);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state      <= KERNEL_EXC;
         q_r        <= RESET_VECTOR;
         epc_r      <= '0;
         cause_r    <= '0;
         bd_r       <= 1'b0;
         badvaddr_r <= '0;
         redirect_r <= 1'b0;
      end else begin
         state      <= state_n;
         q_r        <= q_n;
         epc_r      <= epc_n;
         cause_r    <= cause_n;
         bd_r       <= bd_n;
         badvaddr_r <= badvaddr_n;
         redirect_r <= redirect_n;
      end
   end

   always_comb begin
      state_n    = state;
      q_n        = q_r;
      epc_n      = epc_r;
      cause_n    = cause_r;
      bd_n       = bd_r;
      badvaddr_n = badvaddr_r;
      redirect_n = 1'b0;

      if (bus.exc_req || adel) begin
         q_n        = EXC_VECTOR;
         redirect_n = 1'b1;
         // A nested exception keeps the original return context.
         if (state == NORMAL) begin
            epc_n   = bus.in_delay_slot ? (q_r - WIDTH'(INC)) : q_r;
            bd_n    = bus.in_delay_slot;
            state_n = KERNEL_EXC;
         end
         if (bus.exc_req) begin
            cause_n = bus.exc_code;
         end else begin
            cause_n    = CAUSE_ADEL;
            badvaddr_n = sel_target;
         end
      end else if (bus.e) begin
         if (bus.eret && (state == KERNEL_EXC)) begin
            q_n        = epc_r;
            state_n    = NORMAL;
            redirect_n = 1'b1;
         end else if (bus.jmp) begin
            q_n        = bus.jmp_target;
            redirect_n = 1'b1;
         end else if (bus.br_taken) begin
            q_n        = bus.br_target;
            redirect_n = 1'b1;
         end else begin
            q_n = q_r + WIDTH'(INC);
         end
      end
   end

   assign bus.q        = q_r;
   assign bus.epc      = epc_r;
   assign bus.cause    = cause_r;
   assign bus.bd       = bd_r;
   assign bus.exl      = (state == KERNEL_EXC);
   assign bus.badvaddr = badvaddr_r;
   assign bus.redirect = redirect_r;
endmodule

// File: tb/tb_vpc_ctrl.sv
// Directed bench for vpc_ctrl: reset, stall, exceptions, eret, alignment, wrap.
module tb_vpc_ctrl;
   logic clk  = 1'b0;
   logic clrn = 1'b1;
   int   n_pass  = 0;
   int   n_fail  = 0;
   int   n_total = 0;

   vpc_ctrl_if #(.WIDTH(32)) bus ();

   vpc_ctrl #(
      .WIDTH       (32),
      .RESET_VECTOR(32'h8000_0000),
      .EXC_VECTOR  (32'h8000_0180),
      .INC         (4),
      .ALIGN_BITS  (2)
   ) dut (
      .clk (clk),
      .clrn(clrn),
      .bus (bus.slave)
   );

   // clock/reset block
   always #5 clk = ~clk;

   // scoreboard check
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic idle();
      bus.e             = 1'b0;
      bus.br_taken      = 1'b0;
      bus.br_target     = '0;
      bus.jmp           = 1'b0;
      bus.jmp_target    = '0;
      bus.exc_req       = 1'b0;
      bus.exc_code      = '0;
      bus.in_delay_slot = 1'b0;
      bus.eret          = 1'b0;
   endtask

   // one clock edge, then settle so outputs are sampled away from the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      #3 clrn = 1'b0;
      #1;
      check("rst_q",        bus.q, 32'h8000_0000);
      check("rst_exl",      32'(bus.exl), 32'd1);
      check("rst_epc",      bus.epc, 32'h0);
      check("rst_cause",    32'(bus.cause), 32'd0);
      check("rst_bd",       32'(bus.bd), 32'd0);
      check("rst_badvaddr", bus.badvaddr, 32'h0);
      check("rst_redirect", 32'(bus.redirect), 32'd0);

      // release reset away from the clock edge, then count up
      @(negedge clk);
      clrn  = 1'b1;
      bus.e = 1'b1;
      step(); check("seq1_q", bus.q, 32'h8000_0004); check("seq1_exl", 32'(bus.exl), 32'd1);
      step(); check("seq2_q", bus.q, 32'h8000_0008); check("seq2_exl", 32'(bus.exl), 32'd1);
      step(); check("seq3_q", bus.q, 32'h8000_000C); check("seq3_exl", 32'(bus.exl), 32'd1);
      check("seq3_redirect", 32'(bus.redirect), 32'd0);
      step(); check("seq4_q", bus.q, 32'h8000_0010);

      // stall, including a jump presented while stalled
      bus.e = 1'b0;
      step(); step();
      check("stall_q", bus.q, 32'h8000_0010);
      bus.jmp = 1'b1; bus.jmp_target = 32'h8000_0100;
      step();
      check("stall_jmp_q", bus.q, 32'h8000_0010);
      check("stall_jmp_redirect", 32'(bus.redirect), 32'd0);
      bus.e = 1'b1;
      step();
      check("jmp_q", bus.q, 32'h8000_0100);
      check("jmp_redirect", 32'(bus.redirect), 32'd1);
      idle();
      step();
      check("jmp_hold_q", bus.q, 32'h8000_0100);
      check("redirect_one_cycle", 32'(bus.redirect), 32'd0);

      // eret from reset (epc=0) reaches NORMAL
      bus.e = 1'b1; bus.eret = 1'b1;
      step();
      check("eret0_q", bus.q, 32'h0);
      check("eret0_exl", 32'(bus.exl), 32'd0);
      idle();
      bus.e = 1'b1; bus.jmp = 1'b1; bus.jmp_target = 32'h0040_0024;
      step();
      check("setup_q", bus.q, 32'h0040_0024);

      // delay-slot exception while stalled
      idle();
      bus.exc_req = 1'b1; bus.exc_code = 5'd12; bus.in_delay_slot = 1'b1;
      step();
      check("ds_q",        bus.q, 32'h8000_0180);
      check("ds_epc",      bus.epc, 32'h0040_0020);
      check("ds_bd",       32'(bus.bd), 32'd1);
      check("ds_cause",    32'(bus.cause), 32'd12);
      check("ds_exl",      32'(bus.exl), 32'd1);
      check("ds_redirect", 32'(bus.redirect), 32'd1);
      idle();
      bus.e = 1'b1; bus.eret = 1'b1;
      step();
      check("ds_eret_q",   bus.q, 32'h0040_0020);
      check("ds_eret_exl", 32'(bus.exl), 32'd0);

      // misaligned taken branch
      idle();
      bus.e = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h0040_0102;
      step();
      check("adel_q",        bus.q, 32'h8000_0180);
      check("adel_cause",    32'(bus.cause), 32'd4);
      check("adel_badvaddr", bus.badvaddr, 32'h0040_0102);
      check("adel_epc",      bus.epc, 32'h0040_0020);
      check("adel_bd",       32'(bus.bd), 32'd0);
      check("adel_exl",      32'(bus.exl), 32'd1);

      // back to NORMAL, then jmp and misaligned branch together: jmp wins
      idle();
      bus.e = 1'b1; bus.eret = 1'b1;
      step();
      check("eret2_q", bus.q, 32'h0040_0020);
      idle();
      bus.e = 1'b1;
      bus.jmp = 1'b1; bus.jmp_target = 32'h0040_0000;
      bus.br_taken = 1'b1; bus.br_target = 32'h0040_0103;
      step();
      check("jmp_br_q",   bus.q, 32'h0040_0000);
      check("jmp_br_exl", 32'(bus.exl), 32'd0);
      check("jmp_br_bad", bus.badvaddr, 32'h0040_0102);

      // first-level exception sets epc=0040_0000
      idle();
      bus.e = 1'b1; bus.exc_req = 1'b1; bus.exc_code = 5'd10;
      step();
      check("exc1_epc",   bus.epc, 32'h0040_0000);
      check("exc1_cause", 32'(bus.cause), 32'd10);

      // nested exception together with eret
      idle();
      bus.e = 1'b1; bus.exc_req = 1'b1; bus.exc_code = 5'd8; bus.eret = 1'b1;
      step();
      check("nest_q",     bus.q, 32'h8000_0180);
      check("nest_epc",   bus.epc, 32'h0040_0000);
      check("nest_cause", 32'(bus.cause), 32'd8);
      check("nest_exl",   32'(bus.exl), 32'd1);
      check("nest_bad",   bus.badvaddr, 32'h0040_0102);

      // wrap at the top of the address space
      idle();
      bus.e = 1'b1; bus.jmp = 1'b1; bus.jmp_target = 32'hFFFF_FFFC;
      step();
      check("pre_wrap_q", bus.q, 32'hFFFF_FFFC);
      idle();
      bus.e = 1'b1;
      step();
      check("wrap_q",        bus.q, 32'h0000_0000);
      check("wrap_redirect", 32'(bus.redirect), 32'd0);

      // asynchronous reset mid-cycle
      #2 clrn = 1'b0;
      #1;
      check("areset_q",   bus.q, 32'h8000_0000);
      check("areset_exl", 32'(bus.exl), 32'd1);
      check("areset_epc", bus.epc, 32'h0);
      #3 clrn = 1'b1;
      idle();

      // final report
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/vpc_ctrl.md
Name: vpc_ctrl

Overview:
- Parametrised next-generation virtual program counter for the MIPS32 fetch stage.
- Holds the fetch PC and selects the next PC by fixed priority from exception entry, ERET return, jump, taken branch or sequential increment.
- Owns the exception state: EPC, cause code, branch-delay flag, exception-level bit and bad virtual address.
- Sits between the IF-stage adder/branch logic and instruction memory; the CP0 datapath reads its status outputs.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_VECTOR, 32'h8000_0000, PC value loaded on reset (kseg0 base).
- EXC_VECTOR, 32'h8000_0180, general exception entry address.
- INC, 4, sequential PC increment in bytes.
- ALIGN_BITS, 2, low target bits that must be zero; 0 disables the alignment check.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- e  in  1  advance enable; 0 stalls the PC except for exception entry.
- br_taken  in  1  taken conditional branch.
- br_target  in  WIDTH  branch target.
- jmp  in  1  jump or jump-register.
- jmp_target  in  WIDTH  jump target.
- exc_req  in  1  external exception request from the pipeline.
- exc_code  in  5  cause code for exc_req.
- in_delay_slot  in  1  faulting instruction is in a branch delay slot.
- eret  in  1  exception return.
- q  out  WIDTH  current PC.
- epc  out  WIDTH  exception PC.
- cause  out  5  latched cause code.
- bd  out  1  latched branch-delay flag.
- exl  out  1  exception level.
- badvaddr  out  WIDTH  faulting misaligned target.
- redirect  out  1  one-cycle pulse after any non-sequential PC load.

Behaviour:
- Reset (clrn=0, asynchronous, effective immediately):
  - q=RESET_VECTOR, exl=1.
  - epc=0, cause=0, bd=0, badvaddr=0, redirect=0.
- All other updates occur on the rising edge of clk.
- Internal address error (adel): asserted when the selected jump or branch target has any of bits [ALIGN_BITS-1:0] nonzero.
- Next-PC priority, highest first:
  1. exc_req or adel (ignores e):
     - q<=EXC_VECTOR, redirect<=1.
     - If exl=0: epc<=(in_delay_slot ? q-INC : q), bd<=in_delay_slot, exl<=1.
     - cause<=exc_code when exc_req=1; otherwise cause<=5'd4 (AdEL) and badvaddr<=the offending target.
     - exc_req has priority over adel for cause; badvaddr is updated only when adel is the source.
  2. eret, e=1, exl=1: q<=epc, exl<=0, redirect<=1.
     - eret with exl=0 is ignored and treated as sequential.
  3. jmp, e=1: q<=jmp_target, redirect<=1.
  4. br_taken, e=1: q<=br_target, redirect<=1.
  5. e=1 otherwise: q<=q+INC, modulo 2^WIDTH (wraps, no flag), redirect<=0.
  6. e=0 and no exception: all state holds, redirect<=0.
- Simultaneous jmp and br_taken: jmp wins; only the jmp target is alignment-checked.
- Nested exception (exl=1): vector taken, cause and badvaddr update, epc and bd hold.
- Exception and eret in the same cycle: the exception wins; exl stays 1.
- Latency: one cycle from the request to the new q value. redirect asserts in that same cycle and lasts exactly one cycle.
- Internal states: exl is the mode state, 1 = KERNEL_EXC and 0 = NORMAL.
  - NORMAL→KERNEL_EXC on exception.
  - KERNEL_EXC→NORMAL on eret.

Test Plan:
- Reset, then release clrn with e=1 for 3 cycles → q=8000_0000, 8000_0004, 8000_0008, 8000_000C; exl=1 throughout.
- Stall: q=8000_0010, e=0 for 2 cycles, then jmp=1, jmp_target=8000_0100 while still e=0 → q holds 8000_0010. Raise e → q=8000_0100, redirect pulses once.
- Delay-slot exception: eret to reach exl=0, q=0040_0024, exc_req=1, exc_code=12, in_delay_slot=1, e=0 → q=8000_0180, epc=0040_0020, bd=1, cause=12, exl=1. Next cycle eret, e=1 → q=0040_0020, exl=0.
- Misaligned branch: exl=0, br_taken=1, br_target=0040_0102 → q=8000_0180, cause=4, badvaddr=0040_0102, epc=old q.
- Nested exception plus priority: exl=1, epc=0040_0000, exc_req=1, exc_code=8 together with eret=1 → q=8000_0180, epc stays 0040_0000, cause=8, exl=1.
- Wrap and async reset: WIDTH=32, q=FFFF_FFFC, e=1 → q=0000_0000. Pulse clrn low mid-cycle → q=8000_0000 immediately, before the next clock edge.
